// File: rtl/smart_home_cmd_pkg.sv
// Shared constants for the smart-home UART command link: command bytes,
// expected ACK bytes, status and device codes, and FSM state encodings.
package smart_home_cmd_pkg;

    localparam logic [7:0] CMD_LIGHT_ON  = 8'hF1;
    localparam logic [7:0] CMD_LIGHT_OFF = 8'h6C;
    localparam logic [7:0] CMD_FAN_ON    = 8'hF0;
    localparam logic [7:0] CMD_FAN_OFF   = 8'h66;
    localparam logic [7:0] CMD_ALARM_ON  = 8'h41;
    localparam logic [7:0] CMD_ALARM_OFF = 8'h61;

    localparam logic [7:0] ACK_LIGHT_ON  = 8'h01;
    localparam logic [7:0] ACK_LIGHT_OFF = 8'h04;
    localparam logic [7:0] ACK_FAN_ON    = 8'h02;
    localparam logic [7:0] ACK_FAN_OFF   = 8'h05;
    localparam logic [7:0] ACK_ALARM_ON  = 8'h03;
    localparam logic [7:0] ACK_ALARM_OFF = 8'h06;

    localparam logic [7:0] ERR_UNKNOWN   = 8'hE0;

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_NAK     = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b10;
    localparam logic [1:0] STATUS_BAD     = 2'b11;

    localparam logic [1:0] DEV_LIGHT   = 2'd0;
    localparam logic [1:0] DEV_FAN     = 2'd1;
    localparam logic [1:0] DEV_ALARM   = 2'd2;
    localparam logic [1:0] DEV_ILLEGAL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_ACK,
        ST_CHECK,
        ST_DONE
    } host_state_t;

    typedef enum logic [1:0] {
        RX_HUNT,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic logic [7:0] cmd_byte(input logic [1:0] dev, input logic on);
        case (dev)
            DEV_LIGHT: cmd_byte = on ? CMD_LIGHT_ON : CMD_LIGHT_OFF;
            DEV_FAN:   cmd_byte = on ? CMD_FAN_ON   : CMD_FAN_OFF;
            DEV_ALARM: cmd_byte = on ? CMD_ALARM_ON : CMD_ALARM_OFF;
            default:   cmd_byte = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] ack_expected(input logic [1:0] dev, input logic on);
        case (dev)
            DEV_LIGHT: ack_expected = on ? ACK_LIGHT_ON : ACK_LIGHT_OFF;
            DEV_FAN:   ack_expected = on ? ACK_FAN_ON   : ACK_FAN_OFF;
            DEV_ALARM: ack_expected = on ? ACK_ALARM_ON : ACK_ALARM_OFF;
            default:   ack_expected = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/uart_8n1_phy.sv
// 8N1 UART physical layer: TX serialiser and RX synchroniser/deserialiser.
// tx is forced idle-high whenever the serialiser is not busy, including in reset.
module uart_8n1_phy
    import smart_home_cmd_pkg::*;
#(
    parameter int TICKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    output logic       tx,
    output logic       tx_done,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid
);

    localparam int TW = $clog2(TICKS_PER_BIT + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(TICKS_PER_BIT / 2 - 1);

    logic          tx_busy;
    logic [9:0]    tx_shift;
    logic [3:0]    tx_bit;
    logic [TW-1:0] tx_tick;

    assign tx      = tx_busy ? tx_shift[0] : 1'b1;
    assign tx_done = tx_busy && (tx_tick == TICK_LAST) && (tx_bit == 4'd9);

    // Serialiser: load start/data/stop on tx_start, shift one bit per bit time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy  <= 1'b0;
            tx_shift <= '1;
            tx_bit   <= '0;
            tx_tick  <= '0;
        end else if (!tx_busy) begin
            if (tx_start) begin
                tx_busy  <= 1'b1;
                tx_shift <= {1'b1, tx_byte, 1'b0};
                tx_bit   <= '0;
                tx_tick  <= '0;
            end
        end else if (tx_tick == TICK_LAST) begin
            tx_tick  <= '0;
            tx_shift <= {1'b1, tx_shift[9:1]};
            if (tx_bit == 4'd9) begin
                tx_busy <= 1'b0;
            end else begin
                tx_bit <= tx_bit + 4'd1;
            end
        end else begin
            tx_tick <= tx_tick + TW'(1);
        end
    end

    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    rx_state_t     rx_state;
    rx_state_t     rx_next;
    logic [TW-1:0] rx_tick;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_fall;

    assign rx_fall = rx_prev & ~rx_sync;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // RX state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_HUNT;
        end else begin
            rx_state <= rx_next;
        end
    end

    // RX next state: half-bit start check, eight centre samples, then stop sample.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_HUNT:  if (rx_fall) rx_next = RX_START;
            RX_START: if (rx_tick == TICK_HALF) rx_next = rx_sync ? RX_HUNT : RX_DATA;
            RX_DATA:  if (rx_tick == TICK_LAST && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_tick == TICK_LAST) rx_next = RX_HUNT;
            default:  rx_next = RX_HUNT;
        endcase
    end

    // RX datapath: tick counter, data shift register and the byte-valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_tick  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (rx_state == RX_HUNT || rx_state != rx_next || rx_tick == TICK_LAST) begin
                rx_tick <= '0;
            end else begin
                rx_tick <= rx_tick + TW'(1);
            end
            if (rx_state == RX_START) begin
                rx_bit <= '0;
            end
            if (rx_state == RX_DATA && rx_tick == TICK_LAST) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
            if (rx_state == RX_STOP && rx_tick == TICK_LAST && rx_sync) begin
                rx_valid <= 1'b1;
                rx_byte  <= rx_shift;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_host.sv
// Host-side command initiator: sends one command byte per request, waits for
// the device ACK, classifies it and mirrors light/fan/alarm state.
// Optional macro CMD_RETRY_EN: resend the same byte on TIMEOUT or BAD ACK,
// up to MAX_RETRY extra attempts (NAK is final).
module uart_cmd_host
    import smart_home_cmd_pkg::*;
#(
    parameter int CLOCK_FREQ       = 50000000,
    parameter int BAUD_RATE        = 9600,
    parameter int ACK_TIMEOUT_BITS = 40,
    parameter int MAX_RETRY        = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_dev,
    input  logic       req_on,
    output logic       tx,
    input  logic       rx,
    output logic       busy,
    output logic       done,
    output logic [1:0] status,
    output logic [7:0] ack_byte,
    output logic       light_state,
    output logic       fan_state,
    output logic       alarm_state
);

    localparam int TICKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int TMO_CLKS      = ACK_TIMEOUT_BITS * TICKS_PER_BIT;
    localparam int TMO_W         = $clog2(TMO_CLKS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CLKS - 1);
    localparam int RETRY_W       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
`ifdef CMD_RETRY_EN
    localparam bit RETRY_ENABLED = 1'b1;
`else
    localparam bit RETRY_ENABLED = 1'b0;
`endif

    host_state_t        state;
    host_state_t        next_state;
    logic [7:0]         cmd_q;
    logic [7:0]         exp_q;
    logic [1:0]         dev_q;
    logic               on_q;
    logic [7:0]         ack_rx_q;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [RETRY_W-1:0] retry_cnt;

    logic       tx_start;
    logic [7:0] phy_tx_byte;
    logic       tx_done;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       finish;
    logic [1:0] finish_status;
    logic       take_ack;
    logic       mirror_update;
    logic       retry;
    logic       can_retry;

    assign req_ready   = (state == ST_IDLE);
    assign busy        = ~req_ready;
    assign done        = (state == ST_DONE);
    assign can_retry   = RETRY_ENABLED && (retry_cnt < RETRY_LIMIT);
    assign phy_tx_byte = (state == ST_IDLE) ? cmd_byte(req_dev, req_on) : cmd_q;

    uart_8n1_phy #(
        .TICKS_PER_BIT(TICKS_PER_BIT)
    ) u_phy (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_start (tx_start),
        .tx_byte  (phy_tx_byte),
        .tx       (tx),
        .tx_done  (tx_done),
        .rx       (rx),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid)
    );

    // Transaction FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, frame launch and final status selection.
    always_comb begin
        next_state    = state;
        tx_start      = 1'b0;
        finish        = 1'b0;
        finish_status = STATUS_OK;
        take_ack      = 1'b0;
        mirror_update = 1'b0;
        retry         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_dev == DEV_ILLEGAL) begin
                        next_state    = ST_DONE;
                        finish        = 1'b1;
                        finish_status = STATUS_BAD;
                    end else begin
                        next_state = ST_SEND;
                        tx_start   = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (tx_done) next_state = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (rx_valid) begin
                    next_state = ST_CHECK;
                end else if (tmo_cnt == TMO_LAST) begin
                    if (can_retry) begin
                        next_state = ST_SEND;
                        tx_start   = 1'b1;
                        retry      = 1'b1;
                    end else begin
                        next_state    = ST_DONE;
                        finish        = 1'b1;
                        finish_status = STATUS_TIMEOUT;
                    end
                end
            end
            ST_CHECK: begin
                if (ack_rx_q == exp_q) begin
                    next_state    = ST_DONE;
                    finish        = 1'b1;
                    finish_status = STATUS_OK;
                    take_ack      = 1'b1;
                    mirror_update = 1'b1;
                end else if (ack_rx_q == ERR_UNKNOWN) begin
                    next_state    = ST_DONE;
                    finish        = 1'b1;
                    finish_status = STATUS_NAK;
                    take_ack      = 1'b1;
                end else if (can_retry) begin
                    next_state = ST_SEND;
                    tx_start   = 1'b1;
                    retry      = 1'b1;
                end else begin
                    next_state    = ST_DONE;
                    finish        = 1'b1;
                    finish_status = STATUS_BAD;
                    take_ack      = 1'b1;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Request latch, received ACK capture, reported status and device mirror.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q       <= '0;
            exp_q       <= '0;
            dev_q       <= '0;
            on_q        <= 1'b0;
            ack_rx_q    <= '0;
            status      <= STATUS_OK;
            ack_byte    <= '0;
            light_state <= 1'b0;
            fan_state   <= 1'b0;
            alarm_state <= 1'b0;
        end else begin
            if (state == ST_IDLE && req_valid) begin
                dev_q <= req_dev;
                on_q  <= req_on;
                cmd_q <= cmd_byte(req_dev, req_on);
                exp_q <= ack_expected(req_dev, req_on);
            end
            if (state == ST_WAIT_ACK && rx_valid) begin
                ack_rx_q <= rx_byte;
            end
            if (finish) begin
                status <= finish_status;
            end
            if (take_ack) begin
                ack_byte <= ack_rx_q;
            end
            if (mirror_update) begin
                case (dev_q)
                    DEV_LIGHT: light_state <= on_q;
                    DEV_FAN:   fan_state   <= on_q;
                    DEV_ALARM: alarm_state <= on_q;
                    default:   ;
                endcase
            end
        end
    end

    // ACK timeout: runs only in WAIT_ACK, cleared in every other state, never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state != ST_WAIT_ACK) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_LAST) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Resend counter, cleared while idle so each request starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_cnt <= '0;
        end else if (state == ST_IDLE) begin
            retry_cnt <= '0;
        end else if (retry) begin
            retry_cnt <= retry_cnt + RETRY_W'(1);
        end
    end

endmodule

// File: tb/tb_uart_cmd_host.sv
// Directed self-checking bench for uart_cmd_host at 16 clks per bit.
module tb_uart_cmd_host;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_dev = 2'd0;
    logic       req_on = 1'b0;
    logic       rx = 1'b1;
    logic       req_ready;
    logic       tx;
    logic       busy;
    logic       done;
    logic [1:0] status;
    logic [7:0] ack_byte;
    logic       light_state;
    logic       fan_state;
    logic       alarm_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_cmd_host #(
        .CLOCK_FREQ(160),
        .BAUD_RATE(10),
        .ACK_TIMEOUT_BITS(40),
        .MAX_RETRY(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_dev     (req_dev),
        .req_on      (req_on),
        .tx          (tx),
        .rx          (rx),
        .busy        (busy),
        .done        (done),
        .status      (status),
        .ack_byte    (ack_byte),
        .light_state (light_state),
        .fan_state   (fan_state),
        .alarm_state (alarm_state)
    );

    // Present a request for one clock edge; returns at the negedge after the handshake edge.
    task automatic send_req(input logic [1:0] dev, input logic on);
        @(negedge clk);
        req_valid = 1'b1;
        req_dev   = dev;
        req_on    = on;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Compare tx on 160 consecutive negedges, starting now, with start/data/stop of b.
    task automatic check_frame(input logic [7:0] b, input string name);
        logic [9:0] f;
        int         bad_k;
        logic       bad_got;
        f = {1'b1, b, 1'b0};
        bad_k = -1;
        bad_got = 1'b0;
        for (int k = 0; k < 160; k++) begin
            if (k > 0) @(negedge clk);
            if (tx !== f[k/16] && bad_k < 0) begin
                bad_k = k;
                bad_got = tx;
            end
        end
        checks++;
        if (bad_k >= 0) begin
            errors++;
            $display("[TB] FAIL %s_frame clk %0d of frame: tx=%b, required %b", name, bad_k, bad_got, f[bad_k/16]);
        end
    endtask

    // Drive one 8N1 frame on rx with a chosen stop bit level.
    task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx = f[i];
            repeat (15) @(negedge clk);
        end
        @(negedge clk);
        rx = 1'b1;
    endtask

    // Wait up to bound negedges for done; reports the index (or -1) and whether tx went low.
    task automatic wait_done(input int bound, output int cycles, output bit tx_low_seen);
        cycles = -1;
        tx_low_seen = 1'b0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (tx === 1'b0) tx_low_seen = 1'b1;
            if (done === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    // Wait up to bound negedges for tx to go low; reports the index (or -1).
    task automatic wait_tx_low(input int bound, output int cycles);
        cycles = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx got %b want 1", tx); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
        checks++; if (status !== 2'b00) begin errors++; $display("[TB] FAIL reset_status got %b want 00", status); end
        checks++; if (ack_byte !== 8'h00) begin errors++; $display("[TB] FAIL reset_ack got %h want 00", ack_byte); end
        checks++;
        if ({light_state, fan_state, alarm_state} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_states got %b want 000", {light_state, fan_state, alarm_state});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_light_on();
        int cyc;
        bit txl;
        send_req(2'd0, 1'b1);
        check_frame(8'hF1, "light_on");
        fork
            drive_rx(8'h01, 1'b1);
            wait_done(400, cyc, txl);
        join
        checks++; if (cyc < 0) begin errors++; $display("[TB] FAIL light_on_done not seen within 400 clks"); end
        checks++; if (status !== 2'b00) begin errors++; $display("[TB] FAIL light_on_status got %b want 00", status); end
        checks++; if (ack_byte !== 8'h01) begin errors++; $display("[TB] FAIL light_on_ack got %h want 01", ack_byte); end
        checks++;
        if ({light_state, fan_state, alarm_state} !== 3'b100) begin
            errors++; $display("[TB] FAIL light_on_states got %b want 100", {light_state, fan_state, alarm_state});
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_fan_nak();
        int cyc;
        int low_at;
        bit txl;
        send_req(2'd1, 1'b0);
        check_frame(8'h66, "fan_off");
        fork
            drive_rx(8'hE0, 1'b1);
            wait_done(400, cyc, txl);
        join
        checks++; if (cyc < 0) begin errors++; $display("[TB] FAIL fan_nak_done not seen within 400 clks"); end
        checks++; if (txl !== 1'b0) begin errors++; $display("[TB] FAIL fan_nak_resend tx went low before done"); end
        checks++; if (status !== 2'b01) begin errors++; $display("[TB] FAIL fan_nak_status got %b want 01", status); end
        checks++; if (ack_byte !== 8'hE0) begin errors++; $display("[TB] FAIL fan_nak_ack got %h want E0", ack_byte); end
        checks++;
        if ({light_state, fan_state, alarm_state} !== 3'b100) begin
            errors++; $display("[TB] FAIL fan_nak_states got %b want 100", {light_state, fan_state, alarm_state});
        end
        wait_tx_low(900, low_at);
        checks++; if (low_at >= 0) begin errors++; $display("[TB] FAIL fan_nak_extra_frame tx low %0d clks after done, want none", low_at); end
    endtask

    task automatic test_alarm_timeout();
        int cyc;
        bit txl;
        send_req(2'd2, 1'b1);
        check_frame(8'h41, "alarm_try0");
`ifdef CMD_RETRY_EN
        for (int r = 1; r <= 2; r++) begin
            wait_tx_low(700, cyc);
            checks++;
            if (cyc != 641) begin
                errors++; $display("[TB] FAIL alarm_retry%0d_start got %0d clks want 641", r, cyc);
            end
            if (cyc > 0) check_frame(8'h41, "alarm_retry");
        end
`endif
        wait_done(700, cyc, txl);
        checks++; if (cyc != 641) begin errors++; $display("[TB] FAIL alarm_timeout_delay got %0d clks want 641", cyc); end
        checks++; if (txl !== 1'b0) begin errors++; $display("[TB] FAIL alarm_timeout_extra_frame tx low before done"); end
        checks++; if (status !== 2'b10) begin errors++; $display("[TB] FAIL alarm_timeout_status got %b want 10", status); end
        checks++; if (ack_byte !== 8'hE0) begin errors++; $display("[TB] FAIL alarm_timeout_ack got %h want E0", ack_byte); end
        checks++;
        if ({light_state, fan_state, alarm_state} !== 3'b100) begin
            errors++; $display("[TB] FAIL alarm_timeout_states got %b want 100", {light_state, fan_state, alarm_state});
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_illegal();
        int pulses;
        bit txl;
        @(negedge clk);
        req_valid = 1'b1;
        req_dev   = 2'd3;
        req_on    = 1'b1;
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL illegal_done_cycle1 got %b want 1", done); end
        checks++; if (status !== 2'b11) begin errors++; $display("[TB] FAIL illegal_status got %b want 11", status); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL illegal_busy got %b want 1", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL illegal_done_cycle2 got %b want 0", done); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL illegal_ready got %b want 1", req_ready); end
        req_valid = 1'b0;
        pulses = 0;
        txl = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
            if (tx === 1'b0) txl = 1'b1;
        end
        checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL illegal_second_accept got %0d done pulses want 0", pulses); end
        checks++; if (txl !== 1'b0) begin errors++; $display("[TB] FAIL illegal_tx tx went low, want idle"); end
        checks++; if (ack_byte !== 8'hE0) begin errors++; $display("[TB] FAIL illegal_ack got %h want E0", ack_byte); end
    endtask

    task automatic test_rx_filtering();
        int cyc;
        bit txl;
        send_req(2'd0, 1'b0);
        check_frame(8'h6C, "light_off");
        repeat (5) @(negedge clk);
        fork
            begin
                @(negedge clk);
                rx = 1'b0;
                repeat (5) @(negedge clk);
                rx = 1'b1;
                repeat (20) @(negedge clk);
                drive_rx(8'hE0, 1'b0);
                repeat (20) @(negedge clk);
            end
            wait_done(230, cyc, txl);
        join
        checks++; if (cyc >= 0) begin errors++; $display("[TB] FAIL rx_filter_no_done done at clk %0d, want none", cyc); end
        fork
            drive_rx(8'h04, 1'b1);
            wait_done(400, cyc, txl);
        join
        checks++; if (cyc < 0) begin errors++; $display("[TB] FAIL light_off_done not seen within 400 clks"); end
        checks++; if (status !== 2'b00) begin errors++; $display("[TB] FAIL light_off_status got %b want 00", status); end
        checks++; if (ack_byte !== 8'h04) begin errors++; $display("[TB] FAIL light_off_ack got %h want 04", ack_byte); end
        checks++;
        if ({light_state, fan_state, alarm_state} !== 3'b000) begin
            errors++; $display("[TB] FAIL light_off_states got %b want 000", {light_state, fan_state, alarm_state});
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_async_reset();
        int cyc;
        int pulses;
        bit txl;
        send_req(2'd1, 1'b1);
        check_frame(8'hF0, "fan_on");
        fork
            drive_rx(8'h02, 1'b1);
            wait_done(400, cyc, txl);
        join
        checks++; if (cyc < 0) begin errors++; $display("[TB] FAIL fan_on_done not seen within 400 clks"); end
        checks++;
        if ({light_state, fan_state, alarm_state} !== 3'b010) begin
            errors++; $display("[TB] FAIL fan_on_states got %b want 010", {light_state, fan_state, alarm_state});
        end
        repeat (10) @(negedge clk);
        send_req(2'd0, 1'b1);
        repeat (40) @(negedge clk);
        checks++; if (tx !== 1'b0) begin errors++; $display("[TB] FAIL midframe_tx got %b want 0", tx); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("[TB] FAIL async_reset_tx got %b want 1", tx); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        txl = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
            if (tx === 1'b0) txl = 1'b1;
        end
        checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL post_reset_done got %0d pulses want 0", pulses); end
        checks++; if (txl !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_tx tx went low, want idle"); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready got %b want 1", req_ready); end
        checks++; if (status !== 2'b00) begin errors++; $display("[TB] FAIL post_reset_status got %b want 00", status); end
        checks++;
        if ({light_state, fan_state, alarm_state} !== 3'b000) begin
            errors++; $display("[TB] FAIL post_reset_states got %b want 000", {light_state, fan_state, alarm_state});
        end
    endtask

    initial begin
        test_reset();
        test_light_on();
        test_fan_nak();
        test_alarm_timeout();
        test_illegal();
        test_rx_filtering();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
